pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, giving the maximum number of MEM_WAIT cycles before a forced release (legal range 2..255).
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 i_ifid_rs, i_ifid_rt  in  5 each  source registers of the instruction in IF/ID.
REQ-005 i_idex_memRead  in  1; i_idex_rt  in  5  load flag and destination of the instruction in ID/EX.
REQ-006 i_exmem_branch, i_exmem_zf, i_exmem_memRead, i_exmem_memWrite  in  1 each  EX/MEM buffer outputs.
REQ-007 i_dmem_ready  in  1  data memory completes the current access this cycle.
REQ-008 o_pc_write, o_ifid_write, o_idex_write, o_exmem_write, o_memwb_write  out  1 each  load enables (1 = capture, 0 = hold).
REQ-009 o_ifid_flush, o_idex_flush, o_exmem_flush  out  1 each  load a bubble (all controls 0) instead of the input.
REQ-010 o_pc_src  out  1  1 = PC takes the EX/MEM branch address.
REQ-011 o_dmem_req  out  1  a data memory access is pending.
REQ-012 o_mem_timeout  out  1  sticky flag: a memory access was force-released.
REQ-013 o_stall_count, o_flush_count  out  16 each  saturating performance counters.

Function
REQ-014 FSM states SHALL be RUN and MEM_WAIT; the outputs SHALL be Mealy (combinational from state and inputs), and the counters and flags SHALL be registered.
REQ-015 A memory access is defined as mem = i_exmem_memRead | i_exmem_memWrite; o_dmem_req SHALL equal mem in both states.
REQ-016 Freeze condition: mem & !i_dmem_ready -> all five write enables 0, all flushes 0, o_pc_src 0.
REQ-017 RUN with freeze -> MEM_WAIT next cycle, wait counter loaded with 1.
REQ-018 MEM_WAIT with !i_dmem_ready -> freeze, wait counter +1; when the counter equals TIMEOUT_CYCLES-1 -> set o_mem_timeout, go to RUN, and evaluate that cycle as not frozen.
REQ-019 MEM_WAIT with i_dmem_ready -> not frozen this cycle, go to RUN.
REQ-020 Branch taken (i_exmem_branch & i_exmem_zf, not frozen) -> o_pc_src=1, o_ifid_flush=o_idex_flush=o_exmem_flush=1, all writes 1.
REQ-021 Load-use (i_idex_memRead & i_idex_rt!=0 & (i_idex_rt==i_ifid_rs | i_idex_rt==i_ifid_rt), not frozen, no branch taken) -> o_pc_write=0, o_ifid_write=0, o_idex_flush=1, other writes 1.
REQ-022 Priority SHALL be freeze > branch taken > load-use > normal; normal = all writes 1, flushes 0, o_pc_src 0.
REQ-023 o_stall_count SHALL increment once per cycle in which o_pc_write=0 with rst=0, saturating at 16'hFFFF.
REQ-024 o_flush_count SHALL increment once per branch-taken cycle, saturating at 16'hFFFF.
REQ-025 A register index of 0 SHALL never cause a load-use stall.

Reset
REQ-026 While rst=1: all write enables 0, all flushes 1, o_pc_src 0, o_dmem_req 0, regardless of the inputs.
REQ-027 At the first clock edge with rst=1: state RUN, wait counter 0, o_mem_timeout 0, both counters 0; reset in MEM_WAIT SHALL abandon the access.
REQ-028 o_mem_timeout SHALL clear only on reset.

Structure
REQ-029 Package pipeline_ctrl_pkg SHALL hold the state encoding, TIMEOUT_CYCLES default, and a REG_ZERO constant.
REQ-030 One sub-module, sat_counter16 (enable, sync clear, saturate at max), SHALL be instantiated twice for the counters.

Verification
REQ-031 Load-use: idex_memRead=1, idex_rt=8, ifid_rs=8 -> pc_write=0, ifid_write=0, idex_flush=1 for one cycle; stall_count=1.
REQ-032 idex_rt=0, ifid_rs=0, idex_memRead=1 -> no stall, all writes 1.
REQ-033 Branch: exmem_branch=1, zf=1 while load-use present -> pc_src=1, three flushes=1, pc_write=1; flush_count=1, stall_count unchanged.
REQ-034 exmem_memRead=1, dmem_ready low 3 cycles then high -> 3 freeze cycles (all writes 0), MEM_WAIT, release on the 4th cycle; stall_count=3.
REQ-035 TIMEOUT_CYCLES=4, dmem_ready held 0 -> 3 freeze cycles, then o_mem_timeout=1, return to RUN; the flag persists until rst.
REQ-036 rst=1 asserted mid MEM_WAIT with the counters preloaded near 16'hFFFF -> reset outputs the same cycle; next cycle RUN and counters 0; saturation checked separately by holding a stall for 70000 cycles -> 16'hFFFF.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipeline_ctrl_pkg;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 16;
  localparam int unsigned REG_W              = 5;
  localparam int unsigned WAIT_W             = 8;
  localparam int unsigned CNT_W              = 16;
  localparam logic [REG_W-1:0] REG_ZERO      = REG_W'(0);

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

  // Pipeline control vector, MSB first
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_write;
    logic exmem_write;
    logic memwb_write;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic pc_src;
    logic dmem_req;
  } ctl_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs from the pipeline buffers and the control/perf outputs back to it.
interface pipeline_ctrl_if;
  import pipeline_ctrl_pkg::*;

  logic [REG_W-1:0] i_ifid_rs;
  logic [REG_W-1:0] i_ifid_rt;
  logic             i_idex_memRead;
  logic [REG_W-1:0] i_idex_rt;
  logic             i_exmem_branch;
  logic             i_exmem_zf;
  logic             i_exmem_memRead;
  logic             i_exmem_memWrite;
  logic             i_dmem_ready;

  logic             o_pc_write;
  logic             o_ifid_write;
  logic             o_idex_write;
  logic             o_exmem_write;
  logic             o_memwb_write;
  logic             o_ifid_flush;
  logic             o_idex_flush;
  logic             o_exmem_flush;
  logic             o_pc_src;
  logic             o_dmem_req;
  logic             o_mem_timeout;
  logic [CNT_W-1:0] o_stall_count;
  logic [CNT_W-1:0] o_flush_count;

  modport master (
    output i_ifid_rs, i_ifid_rt, i_idex_memRead, i_idex_rt, i_exmem_branch,
           i_exmem_zf, i_exmem_memRead, i_exmem_memWrite, i_dmem_ready,
    input  o_pc_write, o_ifid_write, o_idex_write, o_exmem_write, o_memwb_write,
           o_ifid_flush, o_idex_flush, o_exmem_flush, o_pc_src, o_dmem_req,
           o_mem_timeout, o_stall_count, o_flush_count
  );

  modport slave (
    input  i_ifid_rs, i_ifid_rt, i_idex_memRead, i_idex_rt, i_exmem_branch,
           i_exmem_zf, i_exmem_memRead, i_exmem_memWrite, i_dmem_ready,
    output o_pc_write, o_ifid_write, o_idex_write, o_exmem_write, o_memwb_write,
           o_ifid_flush, o_idex_flush, o_exmem_flush, o_pc_src, o_dmem_req,
           o_mem_timeout, o_stall_count, o_flush_count
  );

endinterface

// File: rtl/sat_counter16.sv
// 16-bit up counter with synchronous clear that sticks at all-ones.
module sat_counter16
  import pipeline_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: memory freeze with timeout, branch flush,
// load-use stall, plus saturating stall/flush performance counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic           clk,
  input  logic           rst,
  pipeline_ctrl_if.slave bus
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_q, timeout_d;
  logic              mem, tmo_hit, freeze, branch_taken, load_use;
  logic              stall_en, flush_en;
  ctl_t              ctl;

  // Hazard classification; the timed-out wait cycle is treated as not frozen
  always_comb begin
    mem          = bus.i_exmem_memRead | bus.i_exmem_memWrite;
    tmo_hit      = (state_q == ST_MEM_WAIT) && mem && !bus.i_dmem_ready &&
                   (wait_q == WAIT_LAST);
    freeze       = mem && !bus.i_dmem_ready && !tmo_hit;
    branch_taken = !freeze && bus.i_exmem_branch && bus.i_exmem_zf;
    load_use     = !freeze && !branch_taken && bus.i_idex_memRead &&
                   (bus.i_idex_rt != REG_ZERO) &&
                   ((bus.i_idex_rt == bus.i_ifid_rs) || (bus.i_idex_rt == bus.i_ifid_rt));
  end

  // Next state and Mealy control outputs
  always_comb begin
    state_d      = state_q;
    wait_d       = '0;
    timeout_d    = timeout_q | tmo_hit;
    ctl          = '0;
    ctl.dmem_req = mem;

    case (state_q)
      ST_RUN: begin
        if (freeze) begin
          state_d = ST_MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (freeze) begin
          wait_d = wait_q + WAIT_W'(1);
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (!freeze) begin
      ctl.pc_write    = 1'b1;
      ctl.ifid_write  = 1'b1;
      ctl.idex_write  = 1'b1;
      ctl.exmem_write = 1'b1;
      ctl.memwb_write = 1'b1;
      if (branch_taken) begin
        ctl.pc_src      = 1'b1;
        ctl.ifid_flush  = 1'b1;
        ctl.idex_flush  = 1'b1;
        ctl.exmem_flush = 1'b1;
      end else if (load_use) begin
        ctl.pc_write   = 1'b0;
        ctl.ifid_write = 1'b0;
        ctl.idex_flush = 1'b1;
      end
    end

    // Reset forces bubbles everywhere and holds all stages
    if (rst) begin
      ctl             = '0;
      ctl.ifid_flush  = 1'b1;
      ctl.idex_flush  = 1'b1;
      ctl.exmem_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  assign stall_en = !rst && !ctl.pc_write;
  assign flush_en = !rst && branch_taken;

  sat_counter16 u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .en    (stall_en),
    .count (bus.o_stall_count)
  );

  sat_counter16 u_flush_cnt (
    .clk   (clk),
    .clr   (rst),
    .en    (flush_en),
    .count (bus.o_flush_count)
  );

  assign bus.o_pc_write    = ctl.pc_write;
  assign bus.o_ifid_write  = ctl.ifid_write;
  assign bus.o_idex_write  = ctl.idex_write;
  assign bus.o_exmem_write = ctl.exmem_write;
  assign bus.o_memwb_write = ctl.memwb_write;
  assign bus.o_ifid_flush  = ctl.ifid_flush;
  assign bus.o_idex_flush  = ctl.idex_flush;
  assign bus.o_exmem_flush = ctl.exmem_flush;
  assign bus.o_pc_src      = ctl.pc_src;
  assign bus.o_dmem_req    = ctl.dmem_req;
  assign bus.o_mem_timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench: two controllers (timeout 16 and 4) share stimulus and
// are compared against a cycle-level behavioural model.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_ctrl_if b0 ();
  pipeline_ctrl_if b1 ();

  assign b1.i_ifid_rs        = b0.i_ifid_rs;
  assign b1.i_ifid_rt        = b0.i_ifid_rt;
  assign b1.i_idex_memRead   = b0.i_idex_memRead;
  assign b1.i_idex_rt        = b0.i_idex_rt;
  assign b1.i_exmem_branch   = b0.i_exmem_branch;
  assign b1.i_exmem_zf       = b0.i_exmem_zf;
  assign b1.i_exmem_memRead  = b0.i_exmem_memRead;
  assign b1.i_exmem_memWrite = b0.i_exmem_memWrite;
  assign b1.i_dmem_ready     = b0.i_dmem_ready;

  pipeline_ctrl dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  pipeline_ctrl #(.TIMEOUT_CYCLES(4)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  // {5 write enables, 3 flushes, pc_src, dmem_req}
  localparam ctl_t CTL_RESET   = ctl_t'({5'b00000, 3'b111, 1'b0, 1'b0});
  localparam ctl_t CTL_NORMAL  = ctl_t'({5'b11111, 3'b000, 1'b0, 1'b0});
  localparam ctl_t CTL_LOADUSE = ctl_t'({5'b00111, 3'b010, 1'b0, 1'b0});
  localparam ctl_t CTL_BRANCH  = ctl_t'({5'b11111, 3'b111, 1'b1, 1'b0});
  localparam ctl_t CTL_FREEZE  = ctl_t'({5'b00000, 3'b000, 1'b0, 1'b1});
  localparam ctl_t CTL_NORMMEM = ctl_t'({5'b11111, 3'b000, 1'b0, 1'b1});

  int checks = 0;
  int errors = 0;

  // Model: frozen cycles so far in the current access, sticky flag, counters
  int tmo [2] = '{16, 4};
  int fz_run [2];
  bit m_to [2];
  int m_sc [2];
  int m_fc [2];

  function automatic bit m_mem();
    return b0.i_exmem_memRead || b0.i_exmem_memWrite;
  endfunction

  function automatic bit m_freeze(int k);
    return m_mem() && !b0.i_dmem_ready && (fz_run[k] != tmo[k] - 1);
  endfunction

  function automatic bit m_branch(int k);
    return !m_freeze(k) && b0.i_exmem_branch && b0.i_exmem_zf;
  endfunction

  function automatic bit m_loaduse(int k);
    return !m_freeze(k) && !m_branch(k) && b0.i_idex_memRead && (b0.i_idex_rt != 0) &&
           ((b0.i_idex_rt == b0.i_ifid_rs) || (b0.i_idex_rt == b0.i_ifid_rt));
  endfunction

  function automatic ctl_t model_ctl(int k);
    ctl_t c;
    if (rst) return CTL_RESET;
    if (m_freeze(k)) begin
      c = CTL_FREEZE;
      c.dmem_req = m_mem();
      return c;
    end
    if (m_branch(k)) c = CTL_BRANCH;
    else if (m_loaduse(k)) c = CTL_LOADUSE;
    else c = CTL_NORMAL;
    c.dmem_req = m_mem();
    return c;
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        fz_run[k] = 0; m_to[k] = 1'b0; m_sc[k] = 0; m_fc[k] = 0;
      end else begin
        bit fz, br, lu;
        fz = m_freeze(k);
        br = m_branch(k);
        lu = m_loaduse(k);
        if (m_mem() && !b0.i_dmem_ready && fz_run[k] == tmo[k] - 1) m_to[k] = 1'b1;
        fz_run[k] = fz ? fz_run[k] + 1 : 0;
        if ((fz || lu) && m_sc[k] < 65535) m_sc[k]++;
        if (br && m_fc[k] < 65535) m_fc[k]++;
      end
    end
  endtask

  function automatic ctl_t dut_ctl(int k);
    if (k == 0)
      return ctl_t'({b0.o_pc_write, b0.o_ifid_write, b0.o_idex_write, b0.o_exmem_write,
                     b0.o_memwb_write, b0.o_ifid_flush, b0.o_idex_flush, b0.o_exmem_flush,
                     b0.o_pc_src, b0.o_dmem_req});
    return ctl_t'({b1.o_pc_write, b1.o_ifid_write, b1.o_idex_write, b1.o_exmem_write,
                   b1.o_memwb_write, b1.o_ifid_flush, b1.o_idex_flush, b1.o_exmem_flush,
                   b1.o_pc_src, b1.o_dmem_req});
  endfunction

  function automatic int dut_stall(int k);
    return (k == 0) ? int'(b0.o_stall_count) : int'(b1.o_stall_count);
  endfunction

  function automatic int dut_flush(int k);
    return (k == 0) ? int'(b0.o_flush_count) : int'(b1.o_flush_count);
  endfunction

  function automatic bit dut_to(int k);
    return (k == 0) ? b0.o_mem_timeout : b1.o_mem_timeout;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0;
    b0.i_ifid_rs = '0; b0.i_ifid_rt = '0; b0.i_idex_memRead = 1'b0; b0.i_idex_rt = '0;
    b0.i_exmem_branch = 1'b0; b0.i_exmem_zf = 1'b0;
    b0.i_exmem_memRead = 1'b0; b0.i_exmem_memWrite = 1'b0; b0.i_dmem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b0.i_ifid_rs = 5'(3); b0.i_ifid_rt = 5'(3); b0.i_idex_memRead = 1'b1; b0.i_idex_rt = 5'(3);
    b0.i_exmem_branch = 1'b1; b0.i_exmem_zf = 1'b1;
    b0.i_exmem_memRead = 1'b1; b0.i_exmem_memWrite = 1'($urandom_range(0, 1));
    b0.i_dmem_ready = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dut_ctl(k) !== CTL_RESET) begin
        errors++;
        $display("FAIL reset_ctl[%0d]: got %b expected %b", k, dut_ctl(k), CTL_RESET);
      end
    end
    tick();
    idle();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dut_stall(k) != 0 || dut_flush(k) != 0 || dut_to(k) !== 1'b0) begin
        errors++;
        $display("FAIL reset_regs[%0d]: stall %0d flush %0d timeout %b expected 0 0 0",
                 k, dut_stall(k), dut_flush(k), dut_to(k));
      end
    end
    tick();
  endtask

  task automatic test_load_use();
    idle();
    b0.i_idex_memRead = 1'b1; b0.i_idex_rt = 5'(8); b0.i_ifid_rs = 5'(8);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dut_ctl(k) !== CTL_LOADUSE) begin
        errors++;
        $display("FAIL load_use_ctl[%0d]: got %b expected %b", k, dut_ctl(k), CTL_LOADUSE);
      end
    end
    tick();
    idle();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dut_stall(k) != 1 || dut_ctl(k) !== CTL_NORMAL) begin
        errors++;
        $display("FAIL load_use_after[%0d]: stall %0d ctl %b expected 1 %b",
                 k, dut_stall(k), dut_ctl(k), CTL_NORMAL);
      end
    end
    tick();
  endtask

  task automatic test_zero_reg();
    idle();
    b0.i_idex_memRead = 1'b1; b0.i_idex_rt = 5'(0); b0.i_ifid_rs = 5'(0); b0.i_ifid_rt = 5'(0);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dut_ctl(k) !== CTL_NORMAL) begin
        errors++;
        $display("FAIL zero_reg_ctl[%0d]: got %b expected %b", k, dut_ctl(k), CTL_NORMAL);
      end
    end
    tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dut_stall(k) != 1) begin
        errors++;
        $display("FAIL zero_reg_stall[%0d]: got %0d expected 1", k, dut_stall(k));
      end
    end
    tick();
  endtask

  task automatic test_branch();
    idle();
    b0.i_idex_memRead = 1'b1; b0.i_idex_rt = 5'(8); b0.i_ifid_rt = 5'(8);
    b0.i_exmem_branch = 1'b1; b0.i_exmem_zf = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dut_ctl(k) !== CTL_BRANCH) begin
        errors++;
        $display("FAIL branch_ctl[%0d]: got %b expected %b", k, dut_ctl(k), CTL_BRANCH);
      end
    end
    tick();
    idle();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dut_flush(k) != 1 || dut_stall(k) != 1) begin
        errors++;
        $display("FAIL branch_counts[%0d]: flush %0d stall %0d expected 1 1",
                 k, dut_flush(k), dut_stall(k));
      end
    end
    tick();
  endtask

  task automatic test_mem_wait();
    idle();
    b0.i_exmem_memRead = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ctl_t exp;
      b0.i_dmem_ready = (i == 3);
      exp = (i < 3) ? CTL_FREEZE : CTL_NORMMEM;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dut_ctl(k) !== exp) begin
          errors++;
          $display("FAIL mem_wait_ctl[%0d] cycle %0d: got %b expected %b", k, i, dut_ctl(k), exp);
        end
      end
      tick();
    end
    idle();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dut_stall(k) != 4 || dut_to(k) !== 1'b0) begin
        errors++;
        $display("FAIL mem_wait_after[%0d]: stall %0d timeout %b expected 4 0",
                 k, dut_stall(k), dut_to(k));
      end
    end
    tick();
  endtask

  task automatic test_timeout();
    idle();
    b0.i_exmem_memRead = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ctl_t exp1;
      exp1 = (i < 3) ? CTL_FREEZE : CTL_NORMMEM;
      @(negedge clk);
      checks++;
      if (dut_ctl(1) !== exp1 || dut_ctl(0) !== CTL_FREEZE) begin
        errors++;
        $display("FAIL timeout_ctl cycle %0d: t4 %b t16 %b expected %b %b",
                 i, dut_ctl(1), dut_ctl(0), exp1, CTL_FREEZE);
      end
      tick();
    end
    idle();
    @(negedge clk);
    checks++;
    if (b1.o_mem_timeout !== 1'b1 || b0.o_mem_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_flag: t4 %b t16 %b expected 1 0", b1.o_mem_timeout, b0.o_mem_timeout);
    end
    for (int i = 0; i < 5; i++) tick();
    @(negedge clk);
    checks++;
    if (b1.o_mem_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: got %b expected 1", b1.o_mem_timeout);
    end
    tick();
  endtask

  task automatic test_random(int n);
    bit pend;
    for (int c = 0; c < n; c++) begin
      pend = (b0.i_exmem_memRead || b0.i_exmem_memWrite) && !b0.i_dmem_ready && !rst;
      rst = ($urandom_range(0, 63) == 0);
      b0.i_ifid_rs = 5'($urandom_range(0, 3));
      b0.i_ifid_rt = 5'($urandom_range(0, 3));
      b0.i_idex_rt = 5'($urandom_range(0, 3));
      b0.i_idex_memRead = 1'($urandom_range(0, 1));
      b0.i_exmem_branch = ($urandom_range(0, 3) == 0);
      b0.i_exmem_zf = 1'($urandom_range(0, 1));
      if (!pend) begin
        b0.i_exmem_memRead = ($urandom_range(0, 2) == 0);
        b0.i_exmem_memWrite = ($urandom_range(0, 7) == 0);
      end
      b0.i_dmem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dut_ctl(k) !== model_ctl(k)) begin
          errors++;
          $display("FAIL rand_ctl[%0d] cycle %0d: got %b expected %b", k, c, dut_ctl(k), model_ctl(k));
        end
        checks++;
        if (dut_stall(k) != m_sc[k] || dut_flush(k) != m_fc[k] || dut_to(k) !== m_to[k]) begin
          errors++;
          $display("FAIL rand_regs[%0d] cycle %0d: stall %0d flush %0d to %b expected %0d %0d %b",
                   k, c, dut_stall(k), dut_flush(k), dut_to(k), m_sc[k], m_fc[k], m_to[k]);
        end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_saturation();
    idle();
    b0.i_idex_memRead = 1'b1; b0.i_idex_rt = 5'(5); b0.i_ifid_rs = 5'(5);
    for (int i = 0; i < 70000; i++) tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dut_stall(k) != 32'hFFFF) begin
        errors++;
        $display("FAIL saturation[%0d]: got %h expected ffff", k, dut_stall(k));
      end
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    idle();
    b0.i_exmem_memRead = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dut_ctl(k) !== CTL_RESET || dut_stall(k) != 32'hFFFF) begin
        errors++;
        $display("FAIL reset_mid_ctl[%0d]: ctl %b stall %h expected %b ffff",
                 k, dut_ctl(k), dut_stall(k), CTL_RESET);
      end
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dut_stall(k) != 0 || dut_flush(k) != 0 || dut_to(k) !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_regs[%0d]: stall %0d flush %0d to %b expected 0 0 0",
                 k, dut_stall(k), dut_flush(k), dut_to(k));
      end
    end
    // Fresh access after reset: the timeout-4 unit must freeze three full cycles again
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dut_ctl(k) !== model_ctl(k)) begin
          errors++;
          $display("FAIL reset_mid_rerun[%0d] cycle %0d: got %b expected %b",
                   k, i, dut_ctl(k), model_ctl(k));
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_load_use();
    test_zero_reg();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_random(2000);
    test_saturation();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
